// File: rtl/irq_latency_monitor_if.sv
// Register bus bundle for irq_latency_monitor: 16-bit Avalon-MM style slave,
// word addressed, fixed zero wait states.
//
// Handshake: a write is accepted on every rising clk edge where
// chipselect & ~write_n is high; there is no ready/waitrequest, so the master
// may hold or change the request each cycle. readdata is registered from the
// address seen on the previous edge, independent of chipselect.
interface irq_latency_monitor_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/irq_latency_monitor.sv
// irq_latency_monitor: measures how many clk cycles irq_in stays high after a
// rising edge and keeps last/min/max/count statistics readable over a 16-bit
// register bus. dbg_state exposes the FSM state (1 = measuring).
module irq_latency_monitor (
    input  logic                 clk,
    input  logic                 reset_n,
    irq_latency_monitor_if.slave bus,
    input  logic                 irq_in,
    output logic                 dbg_state
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        irq_d;
    logic        enable_q;
    logic [15:0] cnt_q;
    logic [15:0] last_q;
    logic [15:0] min_q;
    logic [15:0] max_q;
    logic [15:0] count_q;
    logic        sat_q;
    logic        wrap_q;

    logic        wr_stb;
    logic        clear_stb;
    logic        status_wr;
    logic        ctrl_wr;
    logic        rise;
    logic        start;
    logic        incr;
    logic        commit;

    // Only the low two CONTROL bits carry meaning.
    logic        unused_wdata;
    assign unused_wdata = ^bus.writedata[15:2];

    assign wr_stb    = bus.chipselect & ~bus.write_n;
    assign status_wr = wr_stb & (bus.address == 3'd0);
    assign ctrl_wr   = wr_stb & (bus.address == 3'd1);
    assign clear_stb = ctrl_wr & bus.writedata[1];
    assign rise      = irq_in & ~irq_d;
    assign dbg_state = (state_q == S_MEASURE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state: clear beats everything, then disable aborts, then irq drop commits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable_q && rise && !clear_stb) state_d = S_MEASURE;
            end
            S_MEASURE: begin
                if (clear_stb || !enable_q || !irq_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes for start, count-up and commit.
    always_comb begin
        start  = 1'b0;
        incr   = 1'b0;
        commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                start = enable_q & rise & ~clear_stb;
            end
            S_MEASURE: begin
                if (!clear_stb && enable_q) begin
                    incr   = irq_in;
                    commit = ~irq_in;
                end
            end
            default: ;
        endcase
    end

    // Edge-detect register, always running regardless of enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_d <= 1'b0;
        else          irq_d <= irq_in;
    end

    // CONTROL enable bit; a combined enable+clear write still sets enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     enable_q <= 1'b0;
        else if (ctrl_wr) enable_q <= bus.writedata[0];
    end

    // Latency counter and statistics; sticky sets come after the STATUS-write clear so a set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 16'd0;
            last_q  <= 16'd0;
            min_q   <= 16'hFFFF;
            max_q   <= 16'd0;
            count_q <= 16'd0;
            sat_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (clear_stb) begin
            cnt_q   <= 16'd0;
            last_q  <= 16'd0;
            min_q   <= 16'hFFFF;
            max_q   <= 16'd0;
            count_q <= 16'd0;
            sat_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            if (status_wr) begin
                sat_q  <= 1'b0;
                wrap_q <= 1'b0;
            end
            if (start) begin
                cnt_q <= 16'd1;
            end
            if (incr) begin
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                if (cnt_q >= 16'hFFFE) sat_q <= 1'b1;
            end
            if (commit) begin
                last_q  <= cnt_q;
                if (cnt_q < min_q) min_q <= cnt_q;
                if (cnt_q > max_q) max_q <= cnt_q;
                count_q <= count_q + 16'd1;
                if (count_q == 16'hFFFF) wrap_q <= 1'b1;
            end
        end
    end

    // Registered read mux, driven from the current address every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= 16'd0;
        end else begin
            case (bus.address)
                3'd0:    bus.readdata <= {13'd0, wrap_q, sat_q, dbg_state};
                3'd1:    bus.readdata <= {15'd0, enable_q};
                3'd2:    bus.readdata <= last_q;
                3'd3:    bus.readdata <= min_q;
                3'd4:    bus.readdata <= max_q;
                3'd5:    bus.readdata <= count_q;
                default: bus.readdata <= 16'd0;
            endcase
        end
    end

endmodule

// File: doc/irq_latency_monitor.md
# irq_latency_monitor

Measures how long the interval timer's interrupt line stays asserted: from the timer raising `irq` until software clears its timeout status and `irq` drops. This is the timer's ISR service latency in `clk` cycles. The block sits directly downstream of the high-resolution timer, with `irq_in` tied to the timer `irq`. It exposes last/min/max latency and an event count through the same 16-bit Avalon-MM slave style as the timer. The board test system uses it to report interrupt-response figures.

## Interface
- No parameters; all datapaths are fixed at 16 bits to match the 16-bit register bus.

Ports:
- `clk` in 1: single clock, shared with the timer and the bus.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 3: register word select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write.
- `writedata` in 16: write data.
- `readdata` out 16: registered read data.
- `irq_in` in 1: monitored interrupt, synchronous to `clk`, no synchronizer.

## Operation
Register map (word addresses):
- 0 STATUS, read: [0] measuring, [1] sat_sticky, [2] wrap_sticky, rest 0.
  - Any write clears [1] and [2].
- 1 CONTROL: [0] enable (r/w).
  - [1] clear: write-only strobe, reads 0.
  - Reads return {15'b0, enable}.
- 2 LAST: most recent committed latency.
- 3 MIN: smallest committed latency.
- 4 MAX: largest committed latency.
- 5 COUNT: number of committed measurements; wraps.
- 6, 7: read 0, writes ignored.
- Writes to 2–5 are ignored. Reads have no side effects.

Edge detect:
- `irq_d` <= `irq_in` every cycle, independent of enable.
- rise = `irq_in` & ~`irq_d`.

State machine, states IDLE and MEASURE:
- IDLE -> MEASURE when enable & rise. Load `cnt` = 1.
- MEASURE, `irq_in`=1: `cnt` <= `cnt`+1, saturating at 16'hFFFF.
  - Reaching saturation sets sat_sticky.
- MEASURE, `irq_in`=0: commit, then -> IDLE.
  - LAST <= `cnt`.
  - MIN <= min(MIN, `cnt`).
  - MAX <= max(MAX, `cnt`).
  - COUNT <= COUNT+1. On the 16'hFFFF -> 0 transition, set wrap_sticky.
- MEASURE and enable=0: abort to IDLE, no commit.
- A clear strobe in any state resets LAST, MIN, MAX, COUNT and both stickies to their reset values, and forces IDLE. Any in-flight measurement is discarded.

Reset values:
- `readdata`=0, `irq_d`=0, state IDLE, `cnt`=0, enable=0.
- LAST=0, MIN=16'hFFFF, MAX=0, COUNT=0, stickies=0.
- MIN reads 16'hFFFF until the first commit.

Boundary rules:
- Enable set while `irq_in` is already high: no rise, so no measurement until the next rising edge.
- Clear and commit in the same cycle: clear wins.
- STATUS write and a sticky set in the same cycle: set wins.
- Writing enable=1 and clear=1 together: statistics clear and enable becomes 1. A rise in that same cycle is ignored.
- Rise in the cycle immediately after a commit (IDLE, `irq_in` pulses 1-0-1): measured normally.

## Timing
- Latency value equals the number of cycles `irq_in` was sampled high: a pulse high for N cycles commits N, for N < 65535.
- Commit registers update on the clock edge that samples `irq_in`=0. They are readable from the next bus read.
- `readdata` is registered from the address decode every cycle: valid one cycle after `address` is presented. No wait states.
- Write strobe = `chipselect` & ~`write_n`. Register updates take effect on the same edge.
- `reset_n` low mid-measurement returns everything to reset values immediately (asynchronous). No commit occurs.

## Test plan
- Reset, enable=1, `irq_in` high 5 cycles -> LAST=5, MIN=5, MAX=5, COUNT=1, STATUS[0]=0.
- Pulses of 7, 3, and 12 cycles -> LAST=12, MIN=3, MAX=12, COUNT=3.
- `irq_in` high 70000 cycles -> LAST=16'hFFFF, STATUS[1]=1. A STATUS write then reads STATUS=0.
- Deassert enable at cycle 4 of a 10-cycle pulse -> no commit, COUNT unchanged. `irq_in` high before enable is set -> ignored until the next rise.
- CONTROL write 16'h3 mid-pulse -> LAST=0, MIN=16'hFFFF, MAX=0, COUNT=0. The pulse is not committed.
- Reset mid-pulse -> readdata=0, all registers at reset values. Reads of address 6/7 return 0.
